// File: rtl/jk_bank_ctrl.sv
// Command-driven J/K excitation controller for an external JK flip-flop bank.
// Tracks the expected bank value and raises a sticky flag on any mismatch.
module jk_bank_ctrl #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [1:0]   cmd_op,
  input  logic [W-1:0] cmd_data,
  input  logic [7:0]   cmd_len,
  input  logic [W-1:0] q_in,
  output logic [W-1:0] j,
  output logic [W-1:0] k,
  output logic [W-1:0] exp_q,
  output logic         busy,
  output logic         done,
  output logic         err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_STEP,
    S_CHECK
  } state_t;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_UP   = 2'b01;
  localparam logic [1:0] OP_DOWN = 2'b10;
  localparam logic [1:0] OP_TOG  = 2'b11;

  state_t       r_state;
  state_t       w_next;
  logic [1:0]   r_op;
  logic [W-1:0] r_data;
  logic [7:0]   r_rem;
  logic [W-1:0] r_exp;
  logic         r_err;
  logic [W-1:0] w_t;
  logic [W-1:0] w_j;
  logic [W-1:0] w_k;

  // Target is always derived from the tracked value, never from q_in.
  always_comb begin
    w_t = r_exp;
    unique case (r_op)
      OP_LOAD: w_t = r_data;
      OP_UP:   w_t = r_exp + 1'b1;
      OP_DOWN: w_t = r_exp - 1'b1;
      OP_TOG:  w_t = r_exp ^ r_data;
      default: w_t = r_exp;
    endcase
  end

  always_comb begin
    w_next = r_state;
    w_j    = '0;
    w_k    = '0;
    unique case (r_state)
      S_IDLE: begin
        if (cmd_valid) begin
          if (cmd_op == OP_LOAD || cmd_len != 8'd0)
            w_next = S_STEP;
          else
            w_next = S_CHECK;
        end
      end
      S_STEP: begin
        if (r_op == OP_TOG) begin
          w_j = r_data;
          w_k = r_data;
        end else begin
          w_j = ~q_in & w_t;
          w_k = q_in & ~w_t;
        end
        if (r_rem == 8'd1)
          w_next = S_CHECK;
      end
      S_CHECK: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_op    <= OP_LOAD;
      r_data  <= '0;
      r_rem   <= 8'd0;
      r_exp   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && cmd_valid) begin
        r_op   <= cmd_op;
        r_data <= cmd_data;
        r_rem  <= (cmd_op == OP_LOAD) ? 8'd1 : cmd_len;
      end
      if (r_state == S_STEP) begin
        r_exp <= w_t;
        r_rem <= r_rem - 8'd1;
      end
      if (r_state != S_IDLE && q_in != r_exp)
        r_err <= 1'b1;
    end
  end

  assign cmd_ready = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_CHECK);
  assign j         = w_j;
  assign k         = w_k;
  assign exp_q     = r_exp;
  assign err       = r_err;

endmodule

// File: tb/tb_jk_bank_ctrl.sv
// Directed bench for jk_bank_ctrl with a behavioural JK bank and a
// scoreboard of expected final values and accept-to-done latencies.
module tb_jk_bank_ctrl;

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [3:0] cmd_data;
  logic [7:0] cmd_len;
  logic [3:0] q_in;
  logic [3:0] j;
  logic [3:0] k;
  logic [3:0] exp_q;
  logic       busy;
  logic       done;
  logic       err;

  logic [3:0] bank;
  logic       stuck0;
  int         cyc;
  int         n_chk;
  int         n_fail;

  typedef struct {
    logic [3:0] q;
    int         lat;
    int         acc;
  } ent_t;

  ent_t sb[$];

  jk_bank_ctrl #(.W(4)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_len(cmd_len),
    .q_in(q_in), .j(j), .k(k), .exp_q(exp_q),
    .busy(busy), .done(done), .err(err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // JK bank: q+ = J~Q | ~K Q
  always @(posedge clk or posedge rst) begin
    if (rst) bank <= 4'b0000;
    else     bank <= (j & ~bank) | (~k & bank);
  end

  assign q_in = bank & ~{3'b000, stuck0};

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic send(input logic [1:0] op, input logic [3:0] d,
                      input logic [7:0] len, input logic [3:0] eq,
                      input int lat);
    ent_t e;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = d;
    cmd_len   = len;
    chk("ready_before_accept", cmd_ready, 1);
    @(posedge clk);
    #1;
    e.q   = eq;
    e.lat = lat;
    e.acc = cyc;
    sb.push_back(e);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input bit chk_jk, input logic [3:0] ej,
                           input logic [3:0] ek);
    ent_t e;
    bit   got;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        chk("sb_nonempty", sb.size(), 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("exp_q_final", exp_q, e.q);
          chk("latency", cyc - e.acc + 1, e.lat);
          chk("bank_final", q_in, e.q);
        end
        if (chk_jk) begin
          chk("j_in_check", j, 0);
          chk("k_in_check", k, 0);
        end
      end else if (chk_jk && busy) begin
        chk("j_step", j, ej);
        chk("k_step", k, ek);
      end
    end
    chk("done_seen", got, 1);
  endtask

  initial begin
    cyc       = 0;
    n_chk     = 0;
    n_fail    = 0;
    stuck0    = 1'b0;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_data  = 4'h0;
    cmd_len   = 8'd0;
    repeat (2) @(negedge clk);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_exp_q", exp_q, 0);
    chk("rst_j", j, 0);
    chk("rst_k", k, 0);
    rst = 1'b0;

    send(2'b00, 4'b1010, 8'd0, 4'b1010, 2);
    wait_done(1'b1, 4'b1010, 4'b0000);
    chk("err_after_load", err, 0);

    send(2'b01, 4'b0000, 8'd7, 4'b0001, 8);
    wait_done(1'b0, 4'b0000, 4'b0000);
    chk("err_after_up", err, 0);

    send(2'b10, 4'b0000, 8'd2, 4'b1111, 3);
    wait_done(1'b0, 4'b0000, 4'b0000);

    send(2'b00, 4'b1010, 8'd9, 4'b1010, 2);
    wait_done(1'b1, 4'b0000, 4'b0101);

    send(2'b11, 4'b0110, 8'd3, 4'b1100, 4);
    wait_done(1'b1, 4'b0110, 4'b0110);

    send(2'b01, 4'b0000, 8'd0, 4'b1100, 1);
    wait_done(1'b1, 4'b0000, 4'b0000);
    chk("err_before_reset", err, 0);

    send(2'b01, 4'b0000, 8'd10, 4'b0000, 11);
    repeat (4) @(negedge clk);
    chk("mid_busy", busy, 1);
    #1;
    rst = 1'b1;
    #1;
    chk("async_j", j, 0);
    chk("async_k", k, 0);
    chk("async_exp_q", exp_q, 0);
    chk("async_busy", busy, 0);
    chk("async_done", done, 0);
    void'(sb.pop_front());
    repeat (2) begin
      @(negedge clk);
      chk("rst_no_done", done, 0);
    end
    rst = 1'b0;
    chk("post_rst_ready", cmd_ready, 1);
    send(2'b00, 4'b0101, 8'd0, 4'b0101, 2);
    wait_done(1'b1, 4'b0101, 4'b0000);
    chk("err_after_rst_load", err, 0);

    send(2'b00, 4'b0000, 8'd0, 4'b0000, 2);
    wait_done(1'b1, 4'b0000, 4'b0101);
    stuck0 = 1'b1;
    send(2'b01, 4'b0000, 8'd3, 4'b0011, 4);
    @(negedge clk);
    chk("fault_err_c1", err, 0);
    @(negedge clk);
    chk("fault_err_c2", err, 0);
    @(negedge clk);
    chk("fault_err_c3", err, 1);
    for (int i = 0; i < 10 && !done; i++) @(negedge clk);
    chk("fault_done", done, 1);
    chk("fault_exp_q", exp_q, 4'b0011);
    void'(sb.pop_front());
    @(negedge clk);
    stuck0 = 1'b0;
    send(2'b00, 4'b0011, 8'd0, 4'b0011, 2);
    wait_done(1'b0, 4'b0000, 4'b0000);
    chk("err_sticky", err, 1);
    chk("sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
